// File: rtl/hdmi_video_pkg.sv
// Shared timing defaults, line-FSM state type and pixel type for the HDMI
// line-buffer read path.
package hdmi_video_pkg;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned H_FP_DEF     = 40;
  localparam int unsigned H_SYNC_DEF   = 128;
  localparam int unsigned H_BP_DEF     = 88;
  localparam int unsigned V_ACTIVE_DEF = 600;
  localparam int unsigned V_FP_DEF     = 1;
  localparam int unsigned V_SYNC_DEF   = 4;
  localparam int unsigned V_BP_DEF     = 23;

  function automatic int unsigned timing_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef enum logic [1:0] {
    LINE_IDLE,
    LINE_OK,
    LINE_MISS
  } line_state_e;

  typedef logic [23:0] pixel_t;

endpackage

// File: rtl/hdmi_timing_gen.sv
// Raster counters for one video clock domain; emits raw (unregistered)
// active/sync/frame-origin flags decoded from the current counter position.
module hdmi_timing_gen
  import hdmi_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [11:0] h_cnt_o,
  output logic        line_active_o,
  output logic        pix_active_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        frame_start_o
);

  localparam logic [11:0] H_LAST   = 12'(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [11:0] V_LAST   = 12'(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + 12'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o       = h_q;
  assign line_active_o = (v_q < 12'(V_ACTIVE));
  assign pix_active_o  = line_active_o && (h_q < 12'(H_ACTIVE));
  assign hs_o          = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_o          = (v_q >= VS_START) && (v_q < VS_END);
  assign frame_start_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/hdmi_linebuf_reader.sv
// Video-side line-buffer reader: line ownership FSM, RAM address path,
// 3-stage pixel-aligned output pipeline and saturating underflow counter.
module hdmi_linebuf_reader
  import hdmi_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        line_ready,
  input  logic [23:0] rd_data,
  output logic [9:0]  rd_addr,
  output logic        line_done,
  output logic        frame_start,
  output logic        underflow,
  output logic [15:0] underflow_cnt,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic        hdmi_de,
  output logic [23:0] hdmi_rgb
);

  logic [11:0] h_cnt;
  logic        line_active, pix_active, hs_raw, vs_raw, fs_raw;

  hdmi_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i         (rd_clk),
    .rst_i         (rd_rst),
    .h_cnt_o       (h_cnt),
    .line_active_o (line_active),
    .pix_active_o  (pix_active),
    .hs_o          (hs_raw),
    .vs_o          (vs_raw),
    .frame_start_o (fs_raw)
  );

  line_state_e state_q, state_d;
  logic [9:0]  rd_addr_q, rd_addr_d;
  logic        line_done_q, line_done_d;
  logic        underflow_q, underflow_d;
  logic [15:0] ucnt_q, ucnt_d;
  logic        fs_q;
  logic        de1_q, hs1_q, vs1_q, blank1_q;
  logic        de2_q, hs2_q, vs2_q, blank2_q;
  logic        de_q, hs_q, vs_q;
  pixel_t      rgb_q, rgb_d;
  logic        sample;

  // Address/done/blank decode from the next state so they line up with the
  // counter position that caused the transition.
  always_comb begin
    sample      = (h_cnt == '0) && line_active;
    state_d     = state_q;
    if (h_cnt == 12'(H_ACTIVE)) state_d = LINE_IDLE;
    if (sample) state_d = line_ready ? LINE_OK : LINE_MISS;
    underflow_d = sample && !line_ready;
    line_done_d = (state_d == LINE_OK) && (h_cnt == 12'(H_ACTIVE - 1));
    rd_addr_d   = (state_d == LINE_OK) ? h_cnt[9:0] : '0;
    ucnt_d      = ucnt_q;
    if (underflow_d && (ucnt_q != '1)) ucnt_d = ucnt_q + 16'd1;
    rgb_d       = (de2_q && !blank2_q) ? rd_data : '0;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q     <= LINE_IDLE;
      rd_addr_q   <= '0;
      line_done_q <= 1'b0;
      underflow_q <= 1'b0;
      ucnt_q      <= '0;
      fs_q        <= 1'b0;
      de1_q       <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      blank1_q    <= 1'b0;
      de2_q       <= 1'b0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      blank2_q    <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      line_done_q <= line_done_d;
      underflow_q <= underflow_d;
      ucnt_q      <= ucnt_d;
      fs_q        <= fs_raw;
      de1_q       <= pix_active;
      hs1_q       <= hs_raw;
      vs1_q       <= vs_raw;
      blank1_q    <= (state_d == LINE_MISS);
      de2_q       <= de1_q;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      blank2_q    <= blank1_q;
      de_q        <= de2_q;
      hs_q        <= hs2_q ? HS_POL : ~HS_POL;
      vs_q        <= vs2_q ? VS_POL : ~VS_POL;
      rgb_q       <= rgb_d;
    end
  end

  assign rd_addr       = rd_addr_q;
  assign line_done     = line_done_q;
  assign frame_start   = fs_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = ucnt_q;
  assign hdmi_hs       = hs_q;
  assign hdmi_vs       = vs_q;
  assign hdmi_de       = de_q;
  assign hdmi_rgb      = rgb_q;

endmodule

// File: tb/tb_hdmi_linebuf_reader.sv
// Directed bench for hdmi_linebuf_reader on a 14x7 raster, plus a second
// one-clock-per-line instance used to drive the underflow counter to saturation.
module tb_hdmi_linebuf_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        line_ready = 1'b1;
  logic [23:0] rd_data = '0;
  logic [9:0]  rd_addr;
  logic        line_done, frame_start, underflow;
  logic [15:0] underflow_cnt;
  logic        hdmi_hs, hdmi_vs, hdmi_de;
  logic [23:0] hdmi_rgb;

  logic        rst2 = 1'b1;
  logic [9:0]  u2_addr;
  logic        u2_ld, u2_fs, u2_uf, u2_hs, u2_vs, u2_de;
  logic [15:0] u2_cnt;
  logic [23:0] u2_rgb;

  int checks = 0;
  int errors = 0;
  int ld_fr[3];
  int vs_fr[3];
  int fs_at[$];

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) rd_data <= 24'h100 + {14'd0, rd_addr};

  hdmi_linebuf_reader #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b1)
  ) dut (
    .rd_clk (rd_clk), .rd_rst (rd_rst), .line_ready (line_ready), .rd_data (rd_data),
    .rd_addr (rd_addr), .line_done (line_done), .frame_start (frame_start),
    .underflow (underflow), .underflow_cnt (underflow_cnt),
    .hdmi_hs (hdmi_hs), .hdmi_vs (hdmi_vs), .hdmi_de (hdmi_de), .hdmi_rgb (hdmi_rgb)
  );

  hdmi_linebuf_reader #(
    .H_ACTIVE (1), .H_FP (0), .H_SYNC (0), .H_BP (0),
    .V_ACTIVE (4093), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b1)
  ) dut_sat (
    .rd_clk (rd_clk), .rd_rst (rst2), .line_ready (1'b0), .rd_data (24'h0),
    .rd_addr (u2_addr), .line_done (u2_ld), .frame_start (u2_fs),
    .underflow (u2_uf), .underflow_cnt (u2_cnt),
    .hdmi_hs (u2_hs), .hdmi_vs (u2_vs), .hdmi_de (u2_de), .hdmi_rgb (u2_rgb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Raster position p counts clocks since reset release: h = p%14, v = (p/14)%7.
  function automatic bit is_miss(input int p, input int mf);
    return (p >= 0) && (mf >= 0) && (p / 98 == mf) && ((p / 14) % 7 == 2);
  endfunction

  function automatic logic ready_at(input int p, input int mf);
    int h = p % 14;
    int v = (p / 14) % 7;
    bit in_fr = (mf >= 0) && (p / 98 == mf);
    if (h == 0 && v >= 4) return 1'b0;
    if (in_fr && h == 0 && v == 2) return 1'b0;
    if (in_fr && h >= 3 && h <= 6) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_cycle(input int k, input int mf);
    int p1 = k - 1;
    int p3 = k - 3;
    int h1 = p1 % 14;
    int v1 = (p1 / 14) % 7;
    int h3, v3;
    bit de3;
    check_eq("frame_start", 32'(frame_start), 32'(h1 == 0 && v1 == 0));
    check_eq("line_done", 32'(line_done), 32'(h1 == 7 && v1 < 4 && !is_miss(p1, mf)));
    check_eq("underflow", 32'(underflow), 32'(h1 == 0 && v1 == 2 && mf >= 0 && p1 / 98 == mf));
    check_eq("rd_addr", 32'(rd_addr), (h1 < 8 && v1 < 4 && !is_miss(p1, mf)) ? 32'(h1) : 32'd0);
    check_eq("underflow_cnt", 32'(underflow_cnt), (mf >= 0 && p1 >= mf * 98 + 28) ? 32'd1 : 32'd0);
    if (p3 < 0) begin
      check_eq("de_flush", 32'(hdmi_de), 32'd0);
      check_eq("rgb_flush", 32'(hdmi_rgb), 32'd0);
      check_eq("hs_flush", 32'(hdmi_hs), 32'd0);
      check_eq("vs_flush", 32'(hdmi_vs), 32'd0);
    end else begin
      h3 = p3 % 14;
      v3 = (p3 / 14) % 7;
      de3 = (h3 < 8) && (v3 < 4);
      check_eq("de", 32'(hdmi_de), 32'(de3));
      check_eq("rgb", 32'(hdmi_rgb), (de3 && !is_miss(p3, mf)) ? 32'h100 + 32'(h3) : 32'd0);
      check_eq("hs", 32'(hdmi_hs), 32'(h3 >= 10 && h3 < 12));
      check_eq("vs", 32'(hdmi_vs), 32'(v3 == 5));
    end
  endtask

  task automatic run_cycles(input int n, input int mf);
    for (int i = 0; i < 3; i++) begin
      ld_fr[i] = 0;
      vs_fr[i] = 0;
    end
    fs_at.delete();
    for (int k = 1; k <= n; k++) begin
      @(posedge rd_clk);
      @(negedge rd_clk);
      check_cycle(k, mf);
      if (line_done && (k - 1) / 98 < 3) ld_fr[(k - 1) / 98]++;
      if (hdmi_vs && k >= 3 && (k - 3) / 98 < 3) vs_fr[(k - 3) / 98]++;
      if (frame_start) fs_at.push_back(k);
      line_ready = ready_at(k, mf);
    end
  endtask

  initial begin
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      check_eq("rst_hs", 32'(hdmi_hs), 32'd0);
      check_eq("rst_vs", 32'(hdmi_vs), 32'd0);
      check_eq("rst_de", 32'(hdmi_de), 32'd0);
      check_eq("rst_rgb", 32'(hdmi_rgb), 32'd0);
      check_eq("rst_addr", 32'(rd_addr), 32'd0);
      check_eq("rst_ucnt", 32'(underflow_cnt), 32'd0);
    end
    rd_rst = 1'b0;
    line_ready = ready_at(0, 1);

    // Frames 0..2 with a late line-2 in frame 1; ends with h_cnt at 5.
    run_cycles(299, 1);
    check_eq("ld_frame0", 32'(ld_fr[0]), 32'd4);
    check_eq("ld_frame1", 32'(ld_fr[1]), 32'd3);
    check_eq("ld_frame2", 32'(ld_fr[2]), 32'd4);
    check_eq("vs_len0", 32'(vs_fr[0]), 32'd14);
    check_eq("vs_len1", 32'(vs_fr[1]), 32'd14);
    check_eq("fs_count", 32'(fs_at.size()), 32'd4);
    if (fs_at.size() == 4) begin
      check_eq("fs_first", 32'(fs_at[0]), 32'd1);
      for (int i = 1; i < 4; i++) check_eq("fs_period", 32'(fs_at[i] - fs_at[i-1]), 32'd98);
    end

    rd_rst = 1'b1;
    #1;
    check_eq("mid_rst_de", 32'(hdmi_de), 32'd0);
    check_eq("mid_rst_rgb", 32'(hdmi_rgb), 32'd0);
    check_eq("mid_rst_hs", 32'(hdmi_hs), 32'd0);
    check_eq("mid_rst_vs", 32'(hdmi_vs), 32'd0);
    check_eq("mid_rst_addr", 32'(rd_addr), 32'd0);
    check_eq("mid_rst_ld", 32'(line_done), 32'd0);
    check_eq("mid_rst_fs", 32'(frame_start), 32'd0);
    check_eq("mid_rst_uf", 32'(underflow), 32'd0);
    check_eq("mid_rst_ucnt", 32'(underflow_cnt), 32'd0);
    #2;
    rd_rst = 1'b0;
    line_ready = 1'b1;
    run_cycles(30, -1);

    // One line per clock, line_ready tied low: 4093 misses per 4096-clock frame.
    @(negedge rd_clk);
    rst2 = 1'b0;
    for (int k = 1; k <= 66000; k++) begin
      @(posedge rd_clk);
      @(negedge rd_clk);
      if (k == 1000)  check_eq("sat_cnt_1000", 32'(u2_cnt), 32'd1000);
      if (k == 65582) check_eq("sat_cnt_fffe", 32'(u2_cnt), 32'hFFFE);
      if (k == 65583) check_eq("sat_cnt_ffff", 32'(u2_cnt), 32'hFFFF);
      if (k == 66000) begin
        check_eq("sat_cnt_hold", 32'(u2_cnt), 32'hFFFF);
        check_eq("sat_uf_pulse", 32'(u2_uf), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
